// File: rtl/divmod_pkg.sv
// Shared definitions for the iterative divide/modulo unit: FSM states,
// default operand width and the iteration-counter width helper.
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divmod_state_t;

  localparam int DIVMOD_WIDTH = 64;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divmod_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module divmod_step
  import divmod_pkg::*;
#(
  parameter int WIDTH = DIVMOD_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             fits_s;

  // The full WIDTH+2 bit compare keeps the top remainder bit in play.
  always_comb begin
    shifted_s = {rem, din};
    fits_s    = (shifted_s >= {2'b00, divisor});
    diff_s    = shifted_s[WIDTH:0] - {1'b0, divisor};
    if (fits_s) begin
      rem_next = diff_s;
      qbit     = 1'b1;
    end else begin
      rem_next = shifted_s[WIDTH:0];
      qbit     = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divmod.sv
// Iterative unsigned divider producing quotient and remainder one bit per
// clock, framed by a start/done handshake with results held until the next done.
module seq_divmod
  import divmod_pkg::*;
#(
  parameter int WIDTH = DIVMOD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  divmod_state_t    state_r;
  divmod_state_t    state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [WIDTH:0]   step_rem_s;
  logic             qbit_s;
  logic             accept_s;
  logic             last_s;
  logic             zero_dvsr_s;

  assign accept_s    = start && (state_r != RUN);
  assign zero_dvsr_s = (divisor == {WIDTH{1'b0}});
  assign last_s      = (state_r == RUN) && (cnt_r == CW'(WIDTH - 1));

  divmod_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_r),
    .din     (work_r[WIDTH-1]),
    .divisor (dvsr_r),
    .rem_next(step_rem_s),
    .qbit    (qbit_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a zero divisor bypasses RUN entirely.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_next_s = zero_dvsr_s ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      RUN: begin
        busy = 1'b1;
        done = 1'b0;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand capture, iteration and result registers; work_r shifts dividend
  // bits out the top while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      rem_r       <= {(WIDTH + 1){1'b0}};
      work_r      <= {WIDTH{1'b0}};
      dvsr_r      <= {WIDTH{1'b0}};
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else if (accept_s) begin
      if (zero_dvsr_s) begin
        quotient    <= {WIDTH{1'b1}};
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        work_r <= dividend;
        dvsr_r <= divisor;
        rem_r  <= {(WIDTH + 1){1'b0}};
        cnt_r  <= {CW{1'b0}};
      end
    end else if (state_r == RUN) begin
      rem_r  <= step_rem_s;
      work_r <= {work_r[WIDTH-2:0], qbit_s};
      cnt_r  <= cnt_r + CW'(1);
      if (last_s) begin
        quotient    <= {work_r[WIDTH-2:0], qbit_s};
        remainder   <= step_rem_s[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divmod.sv
// Directed bench for seq_divmod at WIDTH 8, 16 and 64 with hand-computed
// expectations and a / % reference for the back-to-back sequence.
module tb_seq_divmod;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  dvd8 = 8'd0, dvs8 = 8'd0, q8, r8;
  logic        busy8, done8, dbz8;

  logic        start16 = 1'b0;
  logic [15:0] dvd16 = 16'd0, dvs16 = 16'd0, q16, r16;
  logic        busy16, done16, dbz16;

  logic        start64 = 1'b0;
  logic [63:0] dvd64 = 64'd0, dvs64 = 64'd0, q64, r64;
  logic        busy64, done64, dbz64;

  int n_checks = 0;
  int n_fails  = 0;

  seq_divmod #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  seq_divmod #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .dividend(dvd16), .divisor(dvs16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dbz16)
  );

  seq_divmod #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .start(start64), .dividend(dvd64), .divisor(dvs64),
    .busy(busy64), .done(done64), .quotient(q64), .remainder(r64), .div_by_zero(dbz64)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          n_early;
    logic [15:0] eq, er;

    // Reset state
    tick();
    tick();
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_q8", 64'(q8), 64'd0);
    check("rst_r8", 64'(r8), 64'd0);
    check("rst_dbz64", 64'(dbz64), 64'd0);
    check("rst_q64", q64, 64'd0);
    rst = 1'b0;
    tick();

    // WIDTH=8: 100 / 7, start in cycle 0
    start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
    tick();
    start8 = 1'b0;
    check("t1_busy_c1", 64'(busy8), 64'd1);
    check("t1_done_c1", 64'(done8), 64'd0);
    for (int c = 2; c <= 8; c++) begin
      tick();
      check("t1_busy_run", 64'(busy8), 64'd1);
    end
    tick();
    check("t1_done_c9", 64'(done8), 64'd1);
    check("t1_busy_c9", 64'(busy8), 64'd0);
    check("t1_q", 64'(q8), 64'd14);
    check("t1_r", 64'(r8), 64'd2);
    check("t1_dbz", 64'(dbz8), 64'd0);
    tick();
    check("t1_done_c10", 64'(done8), 64'd0);
    check("t1_q_hold", 64'(q8), 64'd14);

    // WIDTH=8: 200 / 3 with an ignored 50 / 5 start in cycle 3
    start8 = 1'b1; dvd8 = 8'd200; dvs8 = 8'd3;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5;
    tick();
    start8 = 1'b0;
    tick();
    check("t2_q_stable", 64'(q8), 64'd14);
    check("t2_r_stable", 64'(r8), 64'd2);
    tick(); tick(); tick();
    check("t2_done_c8", 64'(done8), 64'd0);
    tick();
    check("t2_done_c9", 64'(done8), 64'd1);
    check("t2_q", 64'(q8), 64'd66);
    check("t2_r", 64'(r8), 64'd2);
    tick();
    check("t2_done_c10", 64'(done8), 64'd0);
    check("t2_no_queue", 64'(busy8), 64'd0);

    // WIDTH=64: divide by zero
    start64 = 1'b1; dvd64 = 64'h1234; dvs64 = 64'd0;
    tick();
    start64 = 1'b0;
    check("t3_done", 64'(done64), 64'd1);
    check("t3_busy", 64'(busy64), 64'd0);
    check("t3_dbz", 64'(dbz64), 64'd1);
    check("t3_q", q64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_r", r64, 64'h1234);
    tick();
    check("t3_done_next", 64'(done64), 64'd0);

    // WIDTH=64: (2^64-1) / 3, done 65 cycles after start
    start64 = 1'b1; dvd64 = 64'hFFFF_FFFF_FFFF_FFFF; dvs64 = 64'd3;
    tick();
    start64 = 1'b0;
    check("t4_busy_c1", 64'(busy64), 64'd1);
    for (int c = 2; c <= 64; c++) begin
      tick();
    end
    check("t4_done_c64", 64'(done64), 64'd0);
    check("t4_q_stable", q64, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("t4_done_c65", 64'(done64), 64'd1);
    check("t4_q", q64, 64'h5555_5555_5555_5555);
    check("t4_r", r64, 64'd0);
    check("t4_dbz_clr", 64'(dbz64), 64'd0);

    // Back-to-back divide-by-zero: done high two cycles running
    start64 = 1'b1; dvd64 = 64'd5; dvs64 = 64'd0;
    tick();
    check("t5_done_a", 64'(done64), 64'd1);
    check("t5_r_a", r64, 64'd5);
    dvd64 = 64'd7;
    tick();
    start64 = 1'b0;
    check("t5_done_b", 64'(done64), 64'd1);
    check("t5_r_b", r64, 64'd7);
    tick();
    check("t5_done_end", 64'(done64), 64'd0);

    // WIDTH=8: reset at iteration 5 aborts, then a fresh 77 / 9
    start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", 64'(busy8), 64'd0);
    check("t6_done", 64'(done8), 64'd0);
    check("t6_q", 64'(q8), 64'd0);
    check("t6_r", 64'(r8), 64'd0);
    check("t6_q64", q64, 64'd0);
    n_early = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done8) n_early++;
    end
    check("t6_no_done", 64'(n_early), 64'd0);
    start8 = 1'b1; dvd8 = 8'd77; dvs8 = 8'd9;
    tick();
    start8 = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      tick();
    end
    check("t6_done_c9", 64'(done8), 64'd1);
    check("t6_q_fresh", 64'(q8), 64'd8);
    check("t6_r_fresh", 64'(r8), 64'd5);

    // WIDTH=16: start held high, one done every 17 cycles
    start16 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        dvd16 = 16'hFFFF; dvs16 = 16'd1;
      end else if (k == 1) begin
        dvd16 = 16'd5; dvs16 = 16'hFFFF;
      end else begin
        dvd16 = 16'($urandom_range(0, 65535));
        dvs16 = 16'($urandom_range(1, 65535));
      end
      eq = dvd16 / dvs16;
      er = dvd16 % dvs16;
      n_early = 0;
      for (int i = 1; i <= 16; i++) begin
        tick();
        if (done16) n_early++;
      end
      tick();
      check("t7_no_early_done", 64'(n_early), 64'd0);
      check("t7_done", 64'(done16), 64'd1);
      check("t7_q", 64'(q16), 64'(eq));
      check("t7_r", 64'(r16), 64'(er));
    end
    start16 = 1'b0;
    tick();
    check("t7_done_end", 64'(done16), 64'd0);
    check("t7_busy_end", 64'(busy16), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seq_divmod.md
# seq_divmod

Iterative unsigned divider that computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. Sits directly upstream of the compare/select/register datapath and supplies both its divide result and its modulo result from a single shared unit in place of two wide combinational dividers. A start/done handshake frames each operation, and the results are held stable until the next accepted start.

## Interface
- WIDTH, 64, operand and result width in bits; legal range is 2 and above.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  operation request; sampled only when the block is not busy.
- dividend  input  WIDTH  unsigned dividend; captured on an accepted start.
- divisor  input  WIDTH  unsigned divisor; captured on an accepted start.
- busy  output  1  high while an iteration is in progress.
- done  output  1  single-cycle pulse; results are valid from this cycle on.
- quotient  output  WIDTH  dividend / divisor.
- remainder  output  WIDTH  dividend % divisor.
- div_by_zero  output  1  set when the captured divisor was 0; cleared by the next accepted start.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: one cycle; done=1.
- Start handling:
  - start is accepted in IDLE or DONE.
  - start is ignored in RUN; there is no queueing.
- Accepted start, divisor != 0:
  - Capture operands.
  - Clear the partial remainder R (WIDTH+1 bits) and the iteration counter.
  - Next state RUN.
- Accepted start, divisor == 0:
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
  - Next state DONE, skipping RUN.
- Restoring step, one per RUN cycle:
  - R' = {R[WIDTH-1:0], next dividend MSB}.
  - If R' >= divisor: R = R' - divisor and shift in quotient bit 1; otherwise R = R' and shift in 0.
- Exit from RUN:
  - After exactly WIDTH steps, write quotient/remainder and go to DONE.
- Leaving DONE:
  - Go to IDLE, or to RUN/DONE if start is accepted in the same cycle (back-to-back).
- Output stability:
  - quotient, remainder and div_by_zero change only on the cycle that enters DONE.
  - They are stable through IDLE and through the following RUN.
- Arithmetic:
  - Unsigned only; no signed handling.
  - The internal remainder is WIDTH+1 bits so the compare never overflows.
- Invariant: quotient*divisor + remainder == dividend, and remainder < divisor, for every divisor != 0.

## Timing
- Reset:
  - State IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Counter and partial remainder are cleared.
- rst wins over start in the same cycle.
- rst during RUN aborts the operation: no done pulse, and outputs return to their reset values at the next edge.
- Normal latency (start accepted in cycle T):
  - busy=1 in cycles T+1 .. T+WIDTH.
  - done=1 in cycle T+WIDTH+1.
  - Total start-to-done latency is WIDTH+1 cycles; WIDTH=64 gives 65.
- Divide-by-zero latency: done=1 in cycle T+1; busy stays 0.
- Throughput: one result per WIDTH+1 cycles when start is held high continuously.
- done is never high for two consecutive cycles, except for back-to-back divide-by-zero requests.

## Structure
- Shared package `divmod_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - Default width constant DIVMOD_WIDTH = 64.
  - Counter-width function $clog2(WIDTH+1).
- One natural combinational sub-module, `divmod_step`:
  - Inputs: the WIDTH+1-bit partial remainder, the dividend bit, and the divisor.
  - Outputs: the next partial remainder and the quotient bit.
  - The top level keeps the FSM, counter, and operand/result registers.

## Test plan
- WIDTH=8; dividend=100, divisor=7, start in cycle 0 -> done in cycle 9, quotient=14, remainder=2, busy high in cycles 1-8.
- WIDTH=64; dividend=2^64-1, divisor=3 -> done 65 cycles after start, quotient=0x5555555555555555, remainder=0.
- Divisor 0, dividend=0x1234 -> done the next cycle with div_by_zero=1, quotient=all ones, remainder=0x1234; the next valid start clears div_by_zero.
- Start pulsed mid-RUN with different operands -> ignored; the first operation's result is reported unchanged at its scheduled done cycle.
- rst asserted at iteration 5 of a WIDTH=8 run -> no done pulse, all outputs 0 next cycle; a fresh start then completes normally.
- Random WIDTH=16 back-to-back operations, start held high, checked against a golden model for / and % -> every done matches, with one done every 17 cycles.
